// File: rtl/stripe_sched_if.sv
// stripe_sched_if: requester handshakes plus striper feed and status for stripe_sched.
// master = requester/striper side, slave = scheduler.
interface stripe_sched_if #(
   parameter int unsigned DATA_W = 32
);
   logic [DATA_W-1:0] req0_data;
   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req1_data;
   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] stripe_data;
   logic              stripe_valid;
   logic [1:0]        grant;
   logic              lane_sel;
   logic [15:0]       cnt0;
   logic [15:0]       cnt1;

   modport master (
      output req0_data, req0_valid, req1_data, req1_valid,
      input  req0_ready, req1_ready, stripe_data, stripe_valid, grant, lane_sel, cnt0, cnt1
   );

   modport slave (
      input  req0_data, req0_valid, req1_data, req1_valid,
      output req0_ready, req1_ready, stripe_data, stripe_valid, grant, lane_sel, cnt0, cnt1
   );
endinterface

// File: rtl/stripe_sched.sv
// stripe_sched: two-requester round-robin scheduler feeding the striper at clk_2f.
// Bursts of up to BURST_MAX words, with one idle cycle of stripe_valid between bursts so the
// striper realigns each burst onto lane0.
// Build option: define LANE_BALANCE_EN to pad odd-length bursts with PAD_WORD so both lanes
// receive the same number of words per burst.
module stripe_sched #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BURST_MAX = 4
`ifdef LANE_BALANCE_EN
   ,
   parameter logic [DATA_W-1:0] PAD_WORD = '0
`endif
) (
   input logic           clk_2f,
   input logic           reset,
   stripe_sched_if.slave bus
);

   localparam logic [3:0] BurstMax = 4'(BURST_MAX);

   typedef enum logic [2:0] {
      StIdle,
      StGrant0,
      StGrant1,
      StGap
`ifdef LANE_BALANCE_EN
      ,
      StPad
`endif
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        burst_cnt_q, burst_cnt_d;
   logic              last_grant_q, last_grant_d;  // 1: requester 1 owned the last burst
   logic              burst_done;
   logic [1:0]        grant_q;
   logic              lane_q, lane_d;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic [15:0]       cnt0_q, cnt1_q;
   logic              xfer0, xfer1, xfer, pad_emit;

   assign bus.req0_ready = (state_q == StGrant0);
   assign bus.req1_ready = (state_q == StGrant1);

   assign xfer0 = bus.req0_valid && bus.req0_ready;
   assign xfer1 = bus.req1_valid && bus.req1_ready;
   assign xfer  = xfer0 || xfer1;

`ifdef LANE_BALANCE_EN
   assign pad_emit = (state_q == StPad);
`else
   assign pad_emit = 1'b0;
`endif

   // Next-state: arbitration, burst length tracking and the mandatory gap between bursts.
   always_comb begin
      state_d      = state_q;
      burst_cnt_d  = burst_cnt_q;
      last_grant_d = last_grant_q;
      burst_done   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
               state_d = StGrant0;
            end else if (bus.req1_valid) begin
               state_d = StGrant1;
            end
         end
         StGrant0, StGrant1: begin
            // Only the owner is ready, so no transfer means the owner dropped valid.
            if (xfer) begin
               burst_cnt_d = burst_cnt_q + 4'd1;
               burst_done  = (burst_cnt_d == BurstMax);
            end else if (burst_cnt_q != 4'd0) begin
               burst_done = 1'b1;
            end else begin
               state_d      = StIdle;
               last_grant_d = (state_q == StGrant1);
            end
         end
         StGap: begin
            burst_cnt_d = '0;
            if (last_grant_q ? bus.req0_valid : bus.req1_valid) begin
               state_d = last_grant_q ? StGrant0 : StGrant1;
            end else if (last_grant_q ? bus.req1_valid : bus.req0_valid) begin
               state_d = last_grant_q ? StGrant1 : StGrant0;
            end else begin
               state_d = StIdle;
            end
         end
`ifdef LANE_BALANCE_EN
         StPad: state_d = StGap;
`endif
         default: state_d = StIdle;
      endcase

      if (burst_done) begin
         last_grant_d = (state_q == StGrant1);
`ifdef LANE_BALANCE_EN
         state_d = burst_cnt_d[0] ? StPad : StGap;
`else
         state_d = StGap;
`endif
      end
   end

   // Lane of the next output word: restarts at lane0 whenever no burst is in progress.
   always_comb begin
      lane_d = lane_q;
      if (state_d == StIdle || state_d == StGap) begin
         lane_d = 1'b0;
      end else if (xfer || pad_emit) begin
         lane_d = ~lane_q;
      end
   end

   // FSM state with grant and lane registered from the next state.
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         burst_cnt_q  <= '0;
         last_grant_q <= 1'b1;
         grant_q      <= '0;
         lane_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         burst_cnt_q  <= burst_cnt_d;
         last_grant_q <= last_grant_d;
         grant_q      <= {state_d == StGrant1, state_d == StGrant0};
         lane_q       <= lane_d;
      end
   end

   // Striper feed and per-requester word counters; data holds while valid is low.
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         valid_q <= xfer || pad_emit;
         if (xfer0) begin
            data_q <= bus.req0_data;
            cnt0_q <= cnt0_q + 16'd1;
         end else if (xfer1) begin
            data_q <= bus.req1_data;
            cnt1_q <= cnt1_q + 16'd1;
         end
`ifdef LANE_BALANCE_EN
         else if (pad_emit) begin
            data_q <= PAD_WORD;
         end
`endif
      end
   end

   assign bus.stripe_data  = data_q;
   assign bus.stripe_valid = valid_q;
   assign bus.grant        = grant_q;
   assign bus.lane_sel     = lane_q;
   assign bus.cnt0         = cnt0_q;
   assign bus.cnt1         = cnt1_q;

endmodule

// File: doc/stripe_sched.md
Name: stripe_sched

Overview:
- Two-requester round-robin scheduler that feeds the 32-bit striping datapath at clk_2f.
- Grants the striper input to one requester at a time, in bounded bursts of words.
- Drives the striper's dataIn/validIn with registered outputs.
- Forces validIn low for at least one cycle between bursts, so the striper realigns each burst onto lane0. Also reports the lane the next word will land on.

Parameters:
- DATA_W, 32, word width of requesters and striper input.
- BURST_MAX, 4, max words per grant; legal range 1..15.
- PAD_WORD, 32'h0000_0000, filler word used only when LANE_BALANCE_EN is defined.

Ports:
- clk_2f  in  1  single clock, the striper's 2f clock.
- reset  in  1  asynchronous, active-low reset.
- req0_data  in  DATA_W  requester 0 word.
- req0_valid  in  1  requester 0 has a word.
- req0_ready  out  1  scheduler accepts requester 0 word this cycle.
- req1_data  in  DATA_W  requester 1 word.
- req1_valid  in  1  requester 1 has a word.
- req1_ready  out  1  scheduler accepts requester 1 word this cycle.
- stripe_data  out  DATA_W  to striper dataIn, registered.
- stripe_valid  out  1  to striper validIn, registered.
- grant  out  2  one-hot current owner; 00 when none.
- lane_sel  out  1  lane of the next output word (0=lane0).
- cnt0  out  16  words accepted from requester 0, wrapping.
- cnt1  out  16  words accepted from requester 1, wrapping.

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, burst_cnt=0, last_grant=1 so requester 0 has first priority.
- Handshake: a word transfers on a posedge where reqN_valid && reqN_ready. reqN_ready=1 only in state GRANTN (combinational from state). The requester must hold data stable while valid && !ready.
- Latency: an accepted word appears on stripe_data with stripe_valid=1 in the next cycle. stripe_valid=0 in every cycle following a cycle with no transfer (or pad). stripe_data holds its last value when stripe_valid=0.
- States: IDLE, GRANT0, GRANT1, GAP, PAD (PAD exists only with the macro).
- IDLE:
  - Outputs idle.
  - If any valid, go to GRANTx, where x is the valid requester.
  - If both are valid, x is the requester != last_grant.
  - Arbitration costs 1 cycle.
- GRANTx:
  - grant=one-hot x.
  - Each transfer increments burst_cnt and cntx (16-bit wrap FFFF->0000).
  - Exit to GAP on the transfer where burst_cnt reaches BURST_MAX.
  - Exit to GAP when reqx_valid=0 with burst_cnt>0 (early end).
  - reqx_valid=0 with burst_cnt=0 goes to IDLE, no gap.
  - last_grant<=x on exit.
- GAP:
  - Exactly one cycle, ready=0, burst_cnt<=0. This guarantees stripe_valid low at least 1 cycle between bursts.
  - Next state: if the other requester is valid, GRANTother. Else if the same requester is valid, GRANTsame. Else IDLE.
- lane_sel: 0 at burst start; toggles on every output word (data or pad); forced 0 in GAP/IDLE.
- Simultaneous events:
  - Both requesters valid at the end of a burst: strict alternation.
  - A requester deasserting valid in the same cycle the other asserts: the GAP rule applies.
- Reset mid-burst: the partial burst is discarded downstream (stripe_valid drops immediately). Counters clear.

Optional Feature:
- Macro LANE_BALANCE_EN.
- Defined: a burst ending with odd burst_cnt goes GRANTx->PAD->GAP. In PAD, ready=0 and one PAD_WORD is emitted with stripe_valid=1 next cycle, so lane0 and lane1 receive equal word counts per burst. Pad words do not increment cnt0/cnt1.
- Not defined: PAD is absent; odd bursts go straight to GAP, and lane0 may carry one more word than lane1.

Test Plan:
- Reset release, both valid continuously, BURST_MAX=4: req0 gets words in cycles 1-4. stripe_valid=1 in cycles 2-5 and 0 in cycle 6. req1 gets words in cycles 6-9. grant sequence is 01,00,10.
- Only req0 valid, 10 words: bursts of 4,4,2 with one-cycle GAP between each. cnt0=10, cnt1=0. lane_sel pattern 0,1,0,1 per burst.
- req1 drops valid after 3 words (macro off): GAP follows, stripe shows 3 valid words. With LANE_BALANCE_EN, a 4th word 0x00000000 appears, and cnt1 still increments by only 3.
- Assert reset mid-burst after 2 of 4 words: all outputs 0 asynchronously. After release, both valid: req0 is granted first.
- Hold req0_valid with ready=0 in IDLE/GAP and change nothing: no transfer, data is not consumed, cnt0 unchanged.
- cnt0 preloaded by 65535 transfers, then 1 more: cnt0 wraps to 0x0000.
